// File: rtl/sdram_port_arb_if.sv
// sdram_port_arb_if: requester and controller signals around the SDRAM port arbiter
// slave  - arbiter side: requester/controller inputs in, acks, read data, ctrl_* command and grant out
// master - surrounding side: loader, CPU bridge, video fetch and SDRAM controller
interface sdram_port_arb_if #(parameter int AW = 25);
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          ioctl_wait;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_wdata;
    logic [1:0]    cpu_be;
    logic          cpu_ack;
    logic [15:0]   cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [15:0]   vid_rdata;
    logic          ctrl_req;
    logic          ctrl_we;
    logic [AW-1:0] ctrl_addr;
    logic [15:0]   ctrl_wdata;
    logic [1:0]    ctrl_be;
    logic          ctrl_ack;
    logic          ctrl_valid;
    logic [15:0]   ctrl_rdata;
    logic [1:0]    grant;
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  vid_req, vid_addr,
        input  ctrl_ack, ctrl_valid, ctrl_rdata,
        output ioctl_wait, cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_be, grant
    );
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output vid_req, vid_addr,
        output ctrl_ack, ctrl_valid, ctrl_rdata,
        input  ioctl_wait, cpu_ack, cpu_rdata, vid_ack, vid_rdata,
        input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata, ctrl_be, grant
    );
endinterface

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: shares one SDRAM controller port among ioctl loader, CPU bridge and video fetch
// clk_ram - sole clock; reset_n - synchronous active-low reset
// b       - slave side of sdram_port_arb_if (requesters in, ctrl_* command out, acks/rdata/grant out)
module sdram_port_arb #(
    parameter int            AW       = 25,
    parameter logic [AW-1:0] ROM_BASE = '0
) (
    input logic clk_ram,
    input logic reset_n,
    sdram_port_arb_if.slave b
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t        state, state_n;
    logic          io_pend, last_vid, io_take, cpu_el, vid_el;
    logic [AW-1:0] io_addr;
    logic [15:0]   io_data;
    logic [1:0]    sel;
    // the ioctl owner has no ack, so its back-pressure drops as soon as the write completes
    assign b.ioctl_wait = io_pend | (b.grant == 2'd1 && state != DONE);
    assign io_take = b.ioctl_wr & ~b.ioctl_wait;
    // last_vid set means video wins the next CPU/video tie; reset 0 lets the CPU win the first one
    always_comb begin
        cpu_el  = b.cpu_req & ~b.ioctl_download;
        vid_el  = b.vid_req & ~b.ioctl_download;
        sel     = io_pend ? 2'd1 : (cpu_el && (!vid_el || !last_vid)) ? 2'd2 : vid_el ? 2'd3 : 2'd0;
        state_n = (state == IDLE && sel != 2'd0) ? ISSUE :
                  (state == ISSUE && b.ctrl_ack) ? WAIT :
                  (state == WAIT && b.ctrl_valid) ? DONE :
                  (state == DONE) ? IDLE : state;
    end
    always_ff @(posedge clk_ram)
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk_ram) begin
        if (!reset_n) begin
            io_pend      <= 1'b0;
            io_addr      <= '0;
            io_data      <= '0;
            last_vid     <= 1'b0;
            b.grant      <= 2'd0;
            b.ctrl_req   <= 1'b0;
            b.ctrl_we    <= 1'b0;
            b.ctrl_addr  <= '0;
            b.ctrl_wdata <= '0;
            b.ctrl_be    <= 2'b00;
            b.cpu_ack    <= 1'b0;
            b.vid_ack    <= 1'b0;
            b.cpu_rdata  <= '0;
            b.vid_rdata  <= '0;
        end else begin
            b.cpu_ack <= 1'b0;
            b.vid_ack <= 1'b0;
            if (io_take) begin
                io_pend <= 1'b1;
                io_addr <= ROM_BASE + b.ioctl_addr;
                io_data <= b.ioctl_dout;
            end
            // command fields only load here, so they hold steady through ISSUE
            if (state == IDLE && sel != 2'd0) begin
                b.ctrl_req   <= 1'b1;
                b.grant      <= sel;
                b.ctrl_we    <= sel == 2'd1 ? 1'b1 : sel == 2'd2 ? b.cpu_we : 1'b0;
                b.ctrl_addr  <= sel == 2'd1 ? io_addr : sel == 2'd2 ? b.cpu_addr : b.vid_addr;
                b.ctrl_wdata <= sel == 2'd1 ? io_data : sel == 2'd2 ? b.cpu_wdata : '0;
                b.ctrl_be    <= sel == 2'd2 ? b.cpu_be : 2'b11;
                if (sel != 2'd1) last_vid <= sel == 2'd2;
            end
            if (state == ISSUE && b.ctrl_ack) begin
                b.ctrl_req <= 1'b0;
                if (b.grant == 2'd1) io_pend <= 1'b0;
            end
            if (state == WAIT && b.ctrl_valid) begin
                b.cpu_ack <= b.grant == 2'd2;
                b.vid_ack <= b.grant == 2'd3;
                if (b.grant == 2'd2 && !b.ctrl_we) b.cpu_rdata <= b.ctrl_rdata;
                if (b.grant == 2'd3) b.vid_rdata <= b.ctrl_rdata;
            end
            if (state == DONE) b.grant <= 2'd0;
        end
    end
    a_ioctl_overrun: assert property (@(posedge clk_ram) disable iff (!reset_n) !(b.ioctl_wr && b.ioctl_wait));
    a_ack_valid: assert property (@(posedge clk_ram) disable iff (!reset_n) !(state == ISSUE && b.ctrl_ack && b.ctrl_valid));
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: cycle vectors plus directed sequences for sdram_port_arb
module tb_sdram_port_arb;
    typedef struct {
        logic        rn, c, v, a, d;
        logic [15:0] rd;
        logic        q;
        logic [1:0]  g;
        logic        ca, va;
        logic [15:0] crd, vrd;
    } vec_t;
    logic clk_ram = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cpu_acks = 0;
    vec_t tv[$];
    sdram_port_arb_if #(.AW(25)) ifc();
    sdram_port_arb_if #(.AW(25)) ifc2();
    sdram_port_arb #(.AW(25), .ROM_BASE(25'h100000)) dut (.clk_ram(clk_ram), .reset_n(reset_n), .b(ifc));
    sdram_port_arb #(.AW(25), .ROM_BASE(25'h4)) dut2 (.clk_ram(clk_ram), .reset_n(reset_n), .b(ifc2));
    always #5 clk_ram = ~clk_ram;
    always @(negedge clk_ram) if (ifc.cpu_ack) cpu_acks++;
    function automatic vec_t mk(logic rn, c, v, a, d, logic [15:0] rd, logic q, logic [1:0] g,
                                logic ca, va, logic [15:0] crd, vrd);
        vec_t t;
        t.rn = rn; t.c = c; t.v = v; t.a = a; t.d = d; t.rd = rd;
        t.q = q; t.g = g; t.ca = ca; t.va = va; t.crd = crd; t.vrd = vrd;
        return t;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // plays the controller: acks in the first ISSUE cycle, returns data in the first WAIT cycle
    task automatic serve(input string nm, input logic [1:0] g, input logic [24:0] a, input logic we,
                         input logic [15:0] wd, input logic [1:0] be, input logic [15:0] rd);
        int n = 0;
        while (!ifc.ctrl_req && n < 20) begin
            @(negedge clk_ram);
            n++;
        end
        chk({nm, "_req"}, 64'(ifc.ctrl_req), 64'(1));
        chk({nm, "_grant"}, 64'(ifc.grant), 64'(g));
        chk({nm, "_cmd"}, 64'({ifc.ctrl_we, ifc.ctrl_addr, ifc.ctrl_be}), 64'({we, a, be}));
        if (we) chk({nm, "_wdata"}, 64'(ifc.ctrl_wdata), 64'(wd));
        ifc.ctrl_ack = 1'b1;
        @(negedge clk_ram);
        ifc.ctrl_ack = 1'b0;
        ifc.ctrl_valid = 1'b1;
        ifc.ctrl_rdata = rd;
        @(negedge clk_ram);
        ifc.ctrl_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        int acks0;
        {ifc.ioctl_download, ifc.ioctl_wr, ifc.ioctl_addr, ifc.ioctl_dout} = '0;
        {ifc.cpu_req, ifc.cpu_we, ifc.cpu_wdata, ifc.cpu_be, ifc.vid_req} = '0;
        {ifc.ctrl_ack, ifc.ctrl_valid, ifc.ctrl_rdata} = '0;
        {ifc2.ioctl_download, ifc2.ioctl_wr, ifc2.ioctl_addr, ifc2.ioctl_dout} = '0;
        {ifc2.cpu_req, ifc2.cpu_we, ifc2.cpu_addr, ifc2.cpu_wdata, ifc2.cpu_be} = '0;
        {ifc2.vid_req, ifc2.vid_addr, ifc2.ctrl_ack, ifc2.ctrl_valid, ifc2.ctrl_rdata} = '0;
        ifc.cpu_addr = 25'h000100;
        ifc.cpu_be = 2'b11;
        ifc.vid_addr = 25'h000200;
        //              rn c v a d rd        q g     ca va crd       vrd
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 1, 2'd2, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 0, 1, 0, 16'h0000, 0, 2'd2, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 0, 0, 1, 16'hBEEF, 0, 2'd2, 1, 0, 16'hBEEF, 16'h0000));
        tv.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'hBEEF, 16'h0000));
        tv.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 2'd2, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 0, 2'd2, 0, 0, 16'h0000, 16'h0000));
        tv.push_back(mk(1, 1, 1, 0, 1, 16'h1111, 0, 2'd2, 1, 0, 16'h1111, 16'h0000));
        tv.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h1111, 16'h0000));
        tv.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 2'd3, 0, 0, 16'h1111, 16'h0000));
        tv.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 0, 2'd3, 0, 0, 16'h1111, 16'h0000));
        tv.push_back(mk(1, 1, 1, 0, 1, 16'h2222, 0, 2'd3, 0, 1, 16'h1111, 16'h2222));
        tv.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h1111, 16'h2222));
        tv.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 2'd2, 0, 0, 16'h1111, 16'h2222));
        tv.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 0, 2'd2, 0, 0, 16'h1111, 16'h2222));
        tv.push_back(mk(1, 1, 1, 0, 1, 16'h3333, 0, 2'd2, 1, 0, 16'h3333, 16'h2222));
        tv.push_back(mk(1, 0, 1, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h3333, 16'h2222));
        tv.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 1, 2'd3, 0, 0, 16'h3333, 16'h2222));
        tv.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 0, 2'd3, 0, 0, 16'h3333, 16'h2222));
        tv.push_back(mk(1, 1, 1, 0, 1, 16'h4444, 0, 2'd3, 0, 1, 16'h3333, 16'h4444));
        tv.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h3333, 16'h4444));
        tv.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0, 0, 16'h3333, 16'h4444));
        foreach (tv[i]) begin
            @(negedge clk_ram);
            reset_n = tv[i].rn;
            ifc.cpu_req = tv[i].c;
            ifc.vid_req = tv[i].v;
            ifc.ctrl_ack = tv[i].a;
            ifc.ctrl_valid = tv[i].d;
            ifc.ctrl_rdata = tv[i].rd;
            @(posedge clk_ram);
            #1;
            chk($sformatf("vec%0d", i),
                64'({ifc.ctrl_req, ifc.grant, ifc.cpu_ack, ifc.vid_ack, ifc.cpu_rdata, ifc.vid_rdata}),
                64'({tv[i].q, tv[i].g, tv[i].ca, tv[i].va, tv[i].crd, tv[i].vrd}));
        end
        // CPU write with ack delayed 5 cycles and valid delayed 7 cycles
        @(negedge clk_ram);
        ifc.cpu_req = 1'b1;
        ifc.cpu_we = 1'b1;
        ifc.cpu_addr = 25'h0ABCDE;
        ifc.cpu_wdata = 16'h00A5;
        ifc.cpu_be = 2'b01;
        @(negedge clk_ram);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("wr_issue%0d", k),
                64'({ifc.ctrl_req, ifc.ctrl_we, ifc.ctrl_addr, ifc.ctrl_wdata, ifc.ctrl_be, ifc.grant}),
                64'({1'b1, 1'b1, 25'h0ABCDE, 16'h00A5, 2'b01, 2'd2}));
            ifc.ctrl_ack = k == 5;
            @(negedge clk_ram);
        end
        ifc.ctrl_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wr_wait%0d", k), 64'({ifc.ctrl_req, ifc.cpu_ack}), 64'(0));
            ifc.ctrl_valid = k == 7;
            ifc.ctrl_rdata = 16'hFFFF;
            @(negedge clk_ram);
        end
        ifc.ctrl_valid = 1'b0;
        chk("wr_ack", 64'(ifc.cpu_ack), 64'(1));
        chk("wr_rdata_kept", 64'(ifc.cpu_rdata), 64'(16'h3333));
        ifc.cpu_req = 1'b0;
        ifc.cpu_we = 1'b0;
        @(negedge clk_ram);
        chk("wr_ack_pulse", 64'({ifc.cpu_ack, ifc.grant}), 64'(0));
        // ROM download locks out a held CPU request
        ifc.cpu_addr = 25'h000100;
        ifc.cpu_be = 2'b11;
        ifc.cpu_req = 1'b1;
        ifc.ioctl_download = 1'b1;
        repeat (3) @(negedge clk_ram);
        chk("dl_lockout", 64'({ifc.ctrl_req, ifc.grant}), 64'(0));
        acks0 = cpu_acks;
        for (int i = 0; i < 8; i++) begin
            ifc.ioctl_wr = 1'b1;
            ifc.ioctl_addr = 25'(2 * i);
            ifc.ioctl_dout = 16'(16'hA000 + i);
            @(negedge clk_ram);
            ifc.ioctl_wr = 1'b0;
            chk($sformatf("io%0d_wait_hi", i), 64'(ifc.ioctl_wait), 64'(1));
            serve($sformatf("io%0d", i), 2'd1, 25'(25'h100000 + 2 * i), 1'b1, 16'(16'hA000 + i), 2'b11, 16'h0);
            chk($sformatf("io%0d_wait_lo", i), 64'(ifc.ioctl_wait), 64'(0));
        end
        ifc.ioctl_download = 1'b0;
        chk("dl_no_cpu_ack", 64'(cpu_acks), 64'(acks0));
        serve("cpu_after_dl", 2'd2, 25'h000100, 1'b0, 16'h0, 2'b11, 16'h5A5A);
        chk("cpu_after_dl_ack", 64'({ifc.cpu_ack, ifc.cpu_rdata}), 64'({1'b1, 16'h5A5A}));
        ifc.cpu_req = 1'b0;
        // reset in the WAIT state of a video read
        @(negedge clk_ram);
        ifc.vid_addr = 25'h001234;
        ifc.vid_req = 1'b1;
        n = 0;
        while (!ifc.ctrl_req && n < 20) begin
            @(negedge clk_ram);
            n++;
        end
        chk("vrst_req", 64'({ifc.ctrl_req, ifc.grant}), 64'({1'b1, 2'd3}));
        ifc.ctrl_ack = 1'b1;
        @(negedge clk_ram);
        ifc.ctrl_ack = 1'b0;
        reset_n = 1'b0;
        ifc.vid_req = 1'b0;
        @(negedge clk_ram);
        chk("vrst_cleared", 64'({ifc.ctrl_req, ifc.grant, ifc.vid_ack, ifc.ioctl_wait}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk_ram);
        ifc.vid_req = 1'b1;
        serve("vid_fresh", 2'd3, 25'h001234, 1'b0, 16'h0, 2'b11, 16'hC0DE);
        chk("vid_fresh_ack", 64'({ifc.vid_ack, ifc.vid_rdata}), 64'({1'b1, 16'hC0DE}));
        ifc.vid_req = 1'b0;
        @(negedge clk_ram);
        chk("vid_ack_pulse", 64'({ifc.vid_ack, ifc.grant}), 64'(0));
        // ROM_BASE + ioctl_addr wraps modulo 2^AW
        ifc2.ioctl_download = 1'b1;
        ifc2.ioctl_addr = 25'h1FFFFFE;
        ifc2.ioctl_dout = 16'h1234;
        ifc2.ioctl_wr = 1'b1;
        @(negedge clk_ram);
        ifc2.ioctl_wr = 1'b0;
        n = 0;
        while (!ifc2.ctrl_req && n < 20) begin
            @(negedge clk_ram);
            n++;
        end
        chk("wrap_cmd", 64'({ifc2.ctrl_req, ifc2.grant, ifc2.ctrl_we, ifc2.ctrl_addr, ifc2.ctrl_be}),
            64'({1'b1, 2'd1, 1'b1, 25'h0000002, 2'b11}));
        ifc2.ctrl_ack = 1'b1;
        @(negedge clk_ram);
        ifc2.ctrl_ack = 1'b0;
        ifc2.ctrl_valid = 1'b1;
        @(negedge clk_ram);
        ifc2.ctrl_valid = 1'b0;
        @(negedge clk_ram);
        chk("wrap_idle", 64'({ifc2.grant, ifc2.ioctl_wait}), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
